mem_stage_lsu: RTL

- Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs and performs the data-memory transaction over a request/grant/response bus.
- It drives the MEM/WB side with registered results.
- It asserts mem_stall to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- It supports RV32I LB/LH/LW/LBU/LHU/SB/SH/SW, with alignment checking and a response timeout.

---
 rtl/mem_stage_lsu.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs one data-memory transaction per access
// instruction over a req/gnt/rvalid bus and produces the registered MEM/WB fields.
//
// state  | meaning
// IDLE   | decode EX/MEM; non-access and rejected ops pass straight to MEM/WB
// REQ    | dmem_req held from latched fields until granted or timed out
// WAIT_R | load granted, waiting for dmem_rvalid
// DONE   | retire latched instruction into MEM/WB, EX/MEM advances
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] load_data_out,
    output logic [4:0]  rd_out,
    output logic        mem_err_out
);

    localparam int unsigned CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] alu;
        logic [31:0] ldata;
        logic [4:0]  rd;
        logic        err;
    } wb_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_f3;
    logic [4:0]    r_rd;
    logic          r_regwrite;
    logic          r_memtoreg;
    logic          r_is_load;
    logic [31:0]   r_ldata;
    logic          r_tmo;
    wb_t           r_wb;

    logic          w_access;
    logic          w_f3_legal;
    logic          w_misaligned;
    logic          w_ok;
    logic          w_req;
    logic          w_tmo;
    logic [3:0]    w_st_strb;
    logic [31:0]   w_st_data;
    logic [7:0]    w_ld_byte;
    logic [15:0]   w_ld_half;
    logic [31:0]   w_ld_ext;

    // MemRead dominates when both access flags are set
    assign w_access = MemRead_in | MemWrite_in;

    always_comb begin
        case (funct3_in)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = MemRead_in;
            default:                w_f3_legal = 1'b0;
        endcase
    end

    assign w_misaligned = ((funct3_in[1:0] == 2'b01) && alu_result_in[0]) ||
                          ((funct3_in[1:0] == 2'b10) && (alu_result_in[1:0] != 2'b00));
    assign w_ok  = w_f3_legal && !w_misaligned;
    assign w_req = (r_state == REQ);
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TMO_LAST));

    // Stall must read 0 while reset is asserted, even with an access op on the inputs
    assign mem_stall = rst_n &&
                       (((r_state == IDLE) && w_access && w_ok) ||
                        (r_state == REQ) || (r_state == WAIT_R));

    always_comb begin
        case (r_f3[1:0])
            2'b00: begin
                w_st_strb = 4'b0001 << r_addr[1:0];
                w_st_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_st_strb = 4'b0011 << {r_addr[1], 1'b0};
                w_st_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_st_strb = 4'b1111;
                w_st_data = r_wdata;
            end
        endcase
    end

    assign dmem_req   = w_req;
    assign dmem_we    = w_req && !r_is_load;
    assign dmem_addr  = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dmem_wstrb = (w_req && !r_is_load) ? w_st_strb : 4'd0;
    assign dmem_wdata = (w_req && !r_is_load) ? w_st_data : 32'd0;

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_ld_byte = dmem_rdata[7:0];
            2'd1:    w_ld_byte = dmem_rdata[15:8];
            2'd2:    w_ld_byte = dmem_rdata[23:16];
            default: w_ld_byte = dmem_rdata[31:24];
        endcase
    end

    assign w_ld_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_ext = {24'd0, w_ld_byte};
            3'b101:  w_ld_ext = {16'd0, w_ld_half};
            default: w_ld_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_f3       <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_is_load  <= 1'b0;
            r_ldata    <= '0;
            r_tmo      <= 1'b0;
            r_wb       <= '0;
        end else begin
            r_wb <= '0;
            case (r_state)
                IDLE: begin
                    if (w_access && w_ok) begin
                        r_addr     <= alu_result_in;
                        r_wdata    <= rs2_data_in;
                        r_f3       <= funct3_in;
                        r_rd       <= rd_in;
                        r_regwrite <= RegWrite_in;
                        r_memtoreg <= MemToReg_in;
                        r_is_load  <= MemRead_in;
                        r_ldata    <= '0;
                        r_tmo      <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= REQ;
                    end else if (w_access) begin
                        r_wb <= '{1'b0, MemToReg_in, alu_result_in, 32'd0, rd_in, 1'b1};
                    end else begin
                        r_wb <= '{RegWrite_in, MemToReg_in, alu_result_in, 32'd0, rd_in, 1'b0};
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        r_cnt   <= '0;
                        r_state <= r_is_load ? WAIT_R : DONE;
                    end else if (w_tmo) begin
                        r_tmo   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid) begin
                        r_ldata <= w_ld_ext;
                        r_state <= DONE;
                    end else if (w_tmo) begin
                        r_tmo   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_wb    <= '{r_regwrite && !r_tmo, r_memtoreg, r_addr, r_ldata, r_rd, r_tmo};
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign RegWrite_out   = r_wb.regwrite;
    assign MemToReg_out   = r_wb.memtoreg;
    assign alu_result_out = r_wb.alu;
    assign load_data_out  = r_wb.ldata;
    assign rd_out         = r_wb.rd;
    assign mem_err_out    = r_wb.err;

endmodule
